// File: rtl/fpu_sched_pkg.sv
// Shared types and constants for the FPU request scheduler
// and its adder power-domain sequencer.
package fpu_sched_pkg;

   typedef enum logic [2:0] {
      M_IDLE,
      M_WAKE,
      M_LAUNCH,
      M_BUSY,
      M_RESP
   } main_st_t;

   typedef enum logic [2:0] {
      P_ON,
      P_DIS,
      P_ISO,
      P_OFF,
      P_UP,
      P_REL
   } pwr_st_t;

   localparam logic [1:0][2:0] ADD_OPS = {3'b001, 3'b000};

   localparam int F_LESS  = 0;
   localparam int F_GREAT = 1;
   localparam int F_EQ    = 2;
   localparam int F_UN    = 3;
   localparam int F_OV    = 4;
   localparam int F_INV   = 5;
   localparam int F_ERR   = 6;

   function automatic logic is_add_op(input logic [2:0] op);
      return (op == ADD_OPS[0]) || (op == ADD_OPS[1]);
   endfunction

endpackage

// File: rtl/fpu_pwr_seq.sv
// Adder power-domain sequencer: idle-driven power-down,
// wake-driven power-up, fixed dwell in each transient step.
module fpu_pwr_seq
   import fpu_sched_pkg::*;
#(
   parameter int IDLE_CYC = 16,
   parameter int SEQ_CYC  = 2
) (
   input  logic clk,
   input  logic rstp,
   input  logic wake_req,
   input  logic idle,
   output logic pwr_on,
   output logic enable_add,
   output logic retain_add,
   output logic isolate_add,
   output logic power_off_add
);

   localparam int IW = $clog2(IDLE_CYC + 1);
   localparam int SW = $clog2(SEQ_CYC + 1);

   pwr_st_t       st;
   pwr_st_t       st_nxt;
   logic [IW-1:0] idle_cnt;
   logic [SW-1:0] step_cnt;
   logic          idle_hit;
   logic          step_done;
   logic          transient;

   assign idle_hit  = idle && (idle_cnt == IW'(IDLE_CYC - 1));
   assign step_done = (step_cnt == SW'(SEQ_CYC - 1));
   assign transient = (st == P_DIS) || (st == P_ISO) ||
                      (st == P_UP)  || (st == P_REL);

   always_comb begin
      st_nxt = st;
      unique case (st)
         P_ON:    if (idle_hit)  st_nxt = P_DIS;
         P_DIS:   if (step_done) st_nxt = P_ISO;
         P_ISO:   if (step_done) st_nxt = P_OFF;
         P_OFF:   if (wake_req)  st_nxt = P_UP;
         P_UP:    if (step_done) st_nxt = P_REL;
         P_REL:   if (step_done) st_nxt = P_ON;
         default: st_nxt = P_ON;
      endcase
   end

   always_ff @(posedge clk or negedge rstp) begin
      if (!rstp) begin
         st       <= P_ON;
         idle_cnt <= '0;
         step_cnt <= '0;
      end else begin
         st <= st_nxt;
         if (!idle)
            idle_cnt <= '0;
         else if (idle_cnt != IW'(IDLE_CYC - 1))
            idle_cnt <= idle_cnt + 1'b1;
         if (transient && !step_done)
            step_cnt <= step_cnt + 1'b1;
         else
            step_cnt <= '0;
      end
   end

   assign pwr_on        = (st == P_ON);
   assign enable_add    = (st == P_ON);
   assign retain_add    = 1'b1;
   assign isolate_add   = (st == P_ISO) || (st == P_OFF) ||
                          (st == P_UP);
   assign power_off_add = (st == P_OFF);

endmodule

// File: rtl/fpu_sched.sv
// Two-client round-robin scheduler driving the shared FPU
// act/done handshake, with adder power gating.
module fpu_sched
   import fpu_sched_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int IDLE_CYC = 16,
   parameter int SEQ_CYC  = 2,
   parameter int TMO_CYC  = 64
) (
   input  logic               clk,
   input  logic               rstp,
   input  logic [1:0]         req,
   input  logic [2*WIDTH-1:0] in1,
   input  logic [2*WIDTH-1:0] in2,
   input  logic [5:0]         opcode,
   input  logic [5:0]         round_m,
   output logic [1:0]         gnt,
   output logic [1:0]         rsp_valid,
   output logic [WIDTH-1:0]   res,
   output logic [6:0]         flags,
   output logic [WIDTH-1:0]   fpu_in1p,
   output logic [WIDTH-1:0]   fpu_in2p,
   output logic [2:0]         fpu_opcode,
   output logic [2:0]         fpu_round_mp,
   output logic               fpu_act,
   input  logic               fpu_done,
   input  logic [WIDTH-1:0]   fpu_out,
   input  logic               fpu_ov,
   input  logic               fpu_un,
   input  logic               fpu_inv,
   input  logic               fpu_eq,
   input  logic               fpu_great,
   input  logic               fpu_less,
   output logic               enable_add,
   output logic               retain_add,
   output logic               isolate_add,
   output logic               power_off_add
);

   localparam int TW = $clog2(TMO_CYC + 1);
   localparam logic [6:0] TMO_FLAGS =
      (7'd1 << F_ERR) | (7'd1 << F_INV);

   main_st_t      st;
   logic          last;
   logic          id;
   logic [TW-1:0] tmo_cnt;
   logic          any_req;
   logic          win;
   logic [2:0]    win_op;
   logic          need_wake;
   logic          wake_req;
   logic          idle;
   logic          pwr_on;
   logic [6:0]    done_flags;

   assign any_req = |req;

   // pointer holds the last winner; the other client wins ties
   always_comb begin
      win = 1'b0;
      unique case (req)
         2'b10:   win = 1'b1;
         2'b11:   win = ~last;
         default: win = 1'b0;
      endcase
   end

   assign win_op    = win ? opcode[5:3] : opcode[2:0];
   assign need_wake = is_add_op(win_op) && !pwr_on;

   assign gnt = (st == M_IDLE && any_req) ?
                (win ? 2'b10 : 2'b01) : 2'b00;
   assign rsp_valid = (st == M_RESP) ?
                      (id ? 2'b10 : 2'b01) : 2'b00;

   // wake starts in the grant cycle to save one cycle of penalty
   assign wake_req = (st == M_WAKE) ||
                     (st == M_IDLE && any_req && need_wake);
   assign idle = (st == M_IDLE) && !any_req;

   always_comb begin
      done_flags          = '0;
      done_flags[F_INV]   = fpu_inv;
      done_flags[F_OV]    = fpu_ov;
      done_flags[F_UN]    = fpu_un;
      done_flags[F_EQ]    = fpu_eq;
      done_flags[F_GREAT] = fpu_great;
      done_flags[F_LESS]  = fpu_less;
   end

   always_ff @(posedge clk or negedge rstp) begin
      if (!rstp) begin
         st           <= M_IDLE;
         last         <= 1'b1;
         id           <= 1'b0;
         tmo_cnt      <= '0;
         fpu_in1p     <= '0;
         fpu_in2p     <= '0;
         fpu_opcode   <= '0;
         fpu_round_mp <= '0;
         fpu_act      <= 1'b1;
         res          <= '0;
         flags        <= '0;
      end else begin
         unique case (st)
            M_IDLE: begin
               if (any_req) begin
                  last         <= win;
                  id           <= win;
                  fpu_opcode   <= win_op;
                  fpu_in1p     <= win ? in1[2*WIDTH-1:WIDTH]
                                      : in1[WIDTH-1:0];
                  fpu_in2p     <= win ? in2[2*WIDTH-1:WIDTH]
                                      : in2[WIDTH-1:0];
                  fpu_round_mp <= win ? round_m[5:3]
                                      : round_m[2:0];
                  if (need_wake) begin
                     st <= M_WAKE;
                  end else begin
                     st      <= M_LAUNCH;
                     fpu_act <= 1'b0;
                  end
               end
            end
            M_WAKE: begin
               if (pwr_on) begin
                  st      <= M_LAUNCH;
                  fpu_act <= 1'b0;
               end
            end
            M_LAUNCH: begin
               st      <= M_BUSY;
               fpu_act <= 1'b1;
               tmo_cnt <= '0;
            end
            M_BUSY: begin
               if (fpu_done) begin
                  res   <= fpu_out;
                  flags <= done_flags;
                  st    <= M_RESP;
               end else if (tmo_cnt == TW'(TMO_CYC - 1)) begin
                  res   <= '0;
                  flags <= TMO_FLAGS;
                  st    <= M_RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            M_RESP:  st <= M_IDLE;
            default: st <= M_IDLE;
         endcase
      end
   end

   fpu_pwr_seq #(
      .IDLE_CYC (IDLE_CYC),
      .SEQ_CYC  (SEQ_CYC)
   ) u_pwr (
      .clk           (clk),
      .rstp          (rstp),
      .wake_req      (wake_req),
      .idle          (idle),
      .pwr_on        (pwr_on),
      .enable_add    (enable_add),
      .retain_add    (retain_add),
      .isolate_add   (isolate_add),
      .power_off_add (power_off_add)
   );

endmodule

// File: tb/tb_fpu_sched.sv
// Directed bench for fpu_sched with a fixed-latency FPU stub
// that can be muted to force the timeout path.
module tb_fpu_sched;

   localparam int W   = 32;
   localparam int IDC = 16;
   localparam int SQC = 2;
   localparam int TMC = 64;

   logic           clk;
   logic           rstp;
   logic [1:0]     req;
   logic [2*W-1:0] in1;
   logic [2*W-1:0] in2;
   logic [5:0]     opcode;
   logic [5:0]     round_m;
   logic [1:0]     gnt;
   logic [1:0]     rsp_valid;
   logic [W-1:0]   res;
   logic [6:0]     flags;
   logic [W-1:0]   fpu_in1p;
   logic [W-1:0]   fpu_in2p;
   logic [2:0]     fpu_opcode;
   logic [2:0]     fpu_round_mp;
   logic           fpu_act;
   logic           fpu_done;
   logic [W-1:0]   fpu_out;
   logic           fpu_ov, fpu_un, fpu_inv;
   logic           fpu_eq, fpu_great, fpu_less;
   logic           enable_add, retain_add;
   logic           isolate_add, power_off_add;

   int n_chk = 0;
   int n_err = 0;

   logic stub_on;
   logic act_prev;
   int   dly;

   fpu_sched #(
      .WIDTH    (W),
      .IDLE_CYC (IDC),
      .SEQ_CYC  (SQC),
      .TMO_CYC  (TMC)
   ) dut (
      .clk           (clk),
      .rstp          (rstp),
      .req           (req),
      .in1           (in1),
      .in2           (in2),
      .opcode        (opcode),
      .round_m       (round_m),
      .gnt           (gnt),
      .rsp_valid     (rsp_valid),
      .res           (res),
      .flags         (flags),
      .fpu_in1p      (fpu_in1p),
      .fpu_in2p      (fpu_in2p),
      .fpu_opcode    (fpu_opcode),
      .fpu_round_mp  (fpu_round_mp),
      .fpu_act       (fpu_act),
      .fpu_done      (fpu_done),
      .fpu_out       (fpu_out),
      .fpu_ov        (fpu_ov),
      .fpu_un        (fpu_un),
      .fpu_inv       (fpu_inv),
      .fpu_eq        (fpu_eq),
      .fpu_great     (fpu_great),
      .fpu_less      (fpu_less),
      .enable_add    (enable_add),
      .retain_add    (retain_add),
      .isolate_add   (isolate_add),
      .power_off_add (power_off_add)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // stub: done pulses 3 cycles after act rises
   always @(negedge clk) begin
      if (!rstp) begin
         dly      = 0;
         fpu_done = 1'b0;
         act_prev = 1'b1;
      end else begin
         fpu_done = 1'b0;
         if (fpu_act && !act_prev) dly = 1;
         else if (dly == 3) begin
            fpu_done = stub_on;
            dly      = 0;
         end else if (dly != 0) dly = dly + 1;
         act_prev = fpu_act;
      end
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cli(input int k, input logic [31:0] a,
                          input logic [31:0] b,
                          input logic [2:0] op);
      in1[k*W +: W]     = a;
      in2[k*W +: W]     = b;
      opcode[k*3 +: 3]  = op;
      round_m[k*3 +: 3] = 3'(k + 1);
   endtask

   task automatic wait_rsp(input string tag, input int max,
                           output int n);
      n = 0;
      while (rsp_valid == 2'b00 && n < max) begin
         tick();
         n++;
      end
      chk({tag, "_seen"}, {31'b0, rsp_valid != 2'b00}, 32'd1);
   endtask

   initial begin
      int n;
      int ev_off, ev_iso, ev_en, ev_act;
      logic bad;

      rstp    = 1'b0;
      req     = 2'b00;
      in1     = '0;
      in2     = '0;
      opcode  = '0;
      round_m = '0;
      stub_on = 1'b1;
      fpu_done  = 1'b0;
      fpu_out   = 32'h3F800000;
      fpu_eq    = 1'b1;
      fpu_ov    = 1'b0;
      fpu_un    = 1'b0;
      fpu_inv   = 1'b0;
      fpu_great = 1'b0;
      fpu_less  = 1'b0;
      repeat (3) tick();
      rstp = 1'b1;
      tick();

      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_rsp", 32'(rsp_valid), 32'h0);
      chk("rst_res", res, 32'h0);
      chk("rst_flags", 32'(flags), 32'h0);
      chk("rst_act", 32'(fpu_act), 32'h1);
      chk("rst_pwr", {28'b0, enable_add, retain_add,
                      isolate_add, power_off_add}, 32'hC);

      // round-robin with both clients requesting
      set_cli(0, 32'h40000000, 32'h40400000, 3'b010);
      set_cli(1, 32'h40800000, 32'h40A00000, 3'b010);
      req = 2'b11;
      #1;
      for (int g = 0; g < 4; g++) begin
         n = 0;
         while (gnt == 2'b00 && n < 50) begin
            tick();
            n++;
         end
         chk($sformatf("s2_gnt%0d", g), 32'(gnt),
             (g % 2 == 1) ? 32'h2 : 32'h1);
         tick();
         if (g == 3) req = 2'b00;
      end
      wait_rsp("s2_rsp", 50, n);
      chk("s2_rsp_id", 32'(rsp_valid), 32'h2);

      // single non-adder op from client 0
      tick();
      set_cli(0, 32'h3F8CCCCD, 32'hBFA66666, 3'b010);
      req = 2'b01;
      #1;
      chk("s1_gnt", 32'(gnt), 32'h1);
      tick();
      req = 2'b00;
      chk("s1_act_lo", 32'(fpu_act), 32'h0);
      chk("s1_in1", fpu_in1p, 32'h3F8CCCCD);
      chk("s1_in2", fpu_in2p, 32'hBFA66666);
      chk("s1_op", 32'(fpu_opcode), 32'h2);
      chk("s1_rm", 32'(fpu_round_mp), 32'h1);
      tick();
      chk("s1_act_hi", 32'(fpu_act), 32'h1);
      wait_rsp("s1_rsp", 20, n);
      chk("s1_lat", n, 32'd4);
      chk("s1_rsp_id", 32'(rsp_valid), 32'h1);
      chk("s1_res", res, 32'h3F800000);
      chk("s1_flags", 32'(flags), 32'h04);

      // idle power-down sequence
      n = 0;
      while (enable_add && n < 100) begin
         tick();
         n++;
      end
      chk("s3_idle_len", n, IDC + 1);
      chk("s1_res_hold", res, 32'h3F800000);
      n = 0;
      while (!isolate_add && n < 20) begin
         tick();
         n++;
      end
      chk("s3_iso_dly", n, SQC);
      chk("s3_en_lo", 32'(enable_add), 32'h0);
      n = 0;
      while (!power_off_add && n < 20) begin
         tick();
         n++;
      end
      chk("s3_off_dly", n, SQC);
      chk("s3_iso_hi", 32'(isolate_add), 32'h1);
      chk("s3_retain", 32'(retain_add), 32'h1);

      // adder op from P_OFF wakes the domain first
      set_cli(0, 32'h3F800000, 32'h3F800000, 3'b000);
      req = 2'b01;
      #1;
      chk("s4_gnt", 32'(gnt), 32'h1);
      ev_off = -1;
      ev_iso = -1;
      ev_en  = -1;
      ev_act = -1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k == 1) req = 2'b00;
         if (ev_off < 0 && !power_off_add) ev_off = k;
         if (ev_iso < 0 && !isolate_add) ev_iso = k;
         if (ev_en < 0 && enable_add) ev_en = k;
         if (ev_act < 0 && !fpu_act) ev_act = k;
      end
      chk("s4_off_lo", ev_off, 32'd1);
      chk("s4_iso_lo", ev_iso, 32'(1 + SQC));
      chk("s4_en_hi", ev_en, 32'(1 + 2 * SQC));
      chk("s4_act_lo", ev_act, 32'(2 + 2 * SQC));
      wait_rsp("s4_rsp", 20, n);
      chk("s4_res", res, 32'h3F800000);

      // non-adder op while powered off does not wake
      n = 0;
      while (!power_off_add && n < 100) begin
         tick();
         n++;
      end
      chk("s4_redown", 32'(power_off_add), 32'h1);
      set_cli(1, 32'h41000000, 32'h40000000, 3'b011);
      req = 2'b10;
      #1;
      chk("s4b_gnt", 32'(gnt), 32'h2);
      tick();
      req = 2'b00;
      chk("s4b_act_lo", 32'(fpu_act), 32'h0);
      chk("s4b_off", 32'(power_off_add), 32'h1);
      wait_rsp("s4b_rsp", 20, n);
      chk("s4b_rsp_id", 32'(rsp_valid), 32'h2);

      // timeout when the FPU never answers
      tick();
      stub_on = 1'b0;
      set_cli(0, 32'h3F800000, 32'h40000000, 3'b010);
      req = 2'b01;
      #1;
      chk("s5_gnt", 32'(gnt), 32'h1);
      tick();
      req = 2'b00;
      tick();
      n = 0;
      while (rsp_valid == 2'b00 && n < 200) begin
         tick();
         n++;
      end
      chk("s5_busy_cyc", n, TMC);
      chk("s5_rsp_id", 32'(rsp_valid), 32'h1);
      chk("s5_res", res, 32'h0);
      chk("s5_flags", 32'(flags), 32'h60);
      stub_on = 1'b1;

      // reset while BUSY
      tick();
      set_cli(0, 32'h12345678, 32'h9ABCDEF0, 3'b010);
      req = 2'b01;
      #1;
      tick();
      req = 2'b00;
      tick();
      tick();
      rstp = 1'b0;
      #1;
      chk("s6_act", 32'(fpu_act), 32'h1);
      chk("s6_rsp", 32'(rsp_valid), 32'h0);
      chk("s6_flags", 32'(flags), 32'h0);
      chk("s6_in1", fpu_in1p, 32'h0);
      chk("s6_op", 32'(fpu_opcode), 32'h0);
      chk("s6_pwr", {28'b0, enable_add, retain_add,
                     isolate_add, power_off_add}, 32'hC);
      tick();
      tick();
      rstp = 1'b1;
      bad  = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (rsp_valid != 2'b00) bad = 1'b1;
      end
      chk("s6_norsp", 32'(bad), 32'h0);
      set_cli(1, 32'h40000000, 32'h40000000, 3'b010);
      req = 2'b11;
      #1;
      chk("s6_gnt", 32'(gnt), 32'h1);
      tick();
      req = 2'b00;
      chk("s6_act_lo", 32'(fpu_act), 32'h0);
      wait_rsp("s6_rsp2", 20, n);
      chk("s6_rsp_id", 32'(rsp_valid), 32'h1);
      chk("s6_res", res, 32'h3F800000);

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule
